// File: rtl/bcd_conv_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// bcd_conv_scheduler_pkg
//   Shared constants and types for the BCD conversion scheduler:
//   channel count and widths, FSM state encoding, and the channel index type.
//   No ports (package).
// -----------------------------------------------------------------------------
package bcd_conv_scheduler_pkg;

   localparam int NUM_CH = 4;   // requester channels
   localparam int CH_W   = 14;  // binary width of one channel
   localparam int BCD_W  = 16;  // four BCD digits per result
   localparam int IDX_W  = 2;   // width of a channel index

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_STORE = 2'd3;

   typedef logic [IDX_W-1:0] ch_idx_t;

   // Index following i, wrapping 3 -> 0.
   function automatic ch_idx_t next_ch(input ch_idx_t i);
      return ch_idx_t'(i + ch_idx_t'(1));
   endfunction

   // Index preceding i, wrapping 0 -> 3.
   function automatic ch_idx_t prev_ch(input ch_idx_t i);
      return ch_idx_t'(i - ch_idx_t'(1));
   endfunction

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// -----------------------------------------------------------------------------
// bcd_conv_scheduler_if
//   Handshake bundle between the scheduler and the shared bin-to-BCD
//   converter.
//     conv_start : one-cycle start pulse            (scheduler -> converter)
//     conv_bin   : operand, held until done/timeout  (scheduler -> converter)
//     conv_done  : one-cycle completion pulse        (converter -> scheduler)
//     conv_bcd   : result, valid while conv_done = 1 (converter -> scheduler)
//   Modports: master = scheduler side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_conv_scheduler_if;
   import bcd_conv_scheduler_pkg::*;

   logic             conv_start;
   logic [CH_W-1:0]  conv_bin;
   logic             conv_done;
   logic [BCD_W-1:0] conv_bcd;

   modport master (
      output conv_start,
      output conv_bin,
      input  conv_done,
      input  conv_bcd
   );

   modport slave (
      input  conv_start,
      input  conv_bin,
      output conv_done,
      output conv_bcd
   );

endinterface

// File: rtl/bcd_conv_scheduler_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational 4-way round-robin selector. The search starts at the
//   channel after 'last' and wraps, so the most recently served channel has
//   the lowest priority.
//   Ports:
//     pending : request bits, one per channel
//     last    : index of the channel served most recently
//     grant   : selected channel index (meaningful only when any = 1)
//     any     : at least one pending bit is set
// -----------------------------------------------------------------------------
module rr_pick4
   import bcd_conv_scheduler_pkg::*;
(
   input  logic [NUM_CH-1:0] pending,
   input  ch_idx_t           last,
   output ch_idx_t           grant,
   output logic              any
);

   // Walk candidates from farthest (last itself) to nearest (last+1); the
   // final hit wins, giving the nearest pending channel after 'last'.
   always_comb begin
      grant = last;
      any   = |pending;
      for (int i = NUM_CH; i >= 1; i--) begin
         if (pending[ch_idx_t'(last + ch_idx_t'(i))]) begin
            grant = ch_idx_t'(last + ch_idx_t'(i));
         end
      end
   end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// -----------------------------------------------------------------------------
// bcd_conv_scheduler
//   Shares one external bin-to-BCD converter among four requester channels.
//   A channel becomes pending when its input differs from the value last
//   issued for it, or on refresh_tick. Pending channels are served
//   round-robin: the operand (clamped to MAX_BIN) is issued, the converter's
//   answer is stored in that channel's bcd_out slice, and an unanswered
//   request times out after TIMEOUT_CYC cycles and is retried later.
//   Ports:
//     clk100Mhz    : clock, rising edge
//     rst          : asynchronous reset, active low
//     ch_bin       : 4 x 14-bit requester values, ch k at [14k+13:14k]
//     refresh_tick : one-cycle pulse, reconvert every channel
//     conv         : converter handshake (master side)
//     bcd_out      : 4 x 16-bit registered BCD results, same packing
//     bcd_valid    : per-channel "slice holds a completed result"
//     busy         : FSM not idle
//     timeout_err  : sticky, a conversion timed out since reset
// -----------------------------------------------------------------------------
module bcd_conv_scheduler
   import bcd_conv_scheduler_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int MAX_BIN     = 9999
) (
   input  logic                      clk100Mhz,
   input  logic                      rst,
   input  logic [NUM_CH*CH_W-1:0]    ch_bin,
   input  logic                      refresh_tick,
   bcd_conv_scheduler_if.master      conv,
   output logic [NUM_CH*BCD_W-1:0]   bcd_out,
   output logic [NUM_CH-1:0]         bcd_valid,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   // Saturate an operand to the largest value the converter is given.
   function automatic logic [CH_W-1:0] clamp_bin(input logic [CH_W-1:0] v);
      if (int'(v) > MAX_BIN) begin
         return CH_W'(MAX_BIN);
      end
      return v;
   endfunction

   logic [1:0]        state;
   ch_idx_t           cur_ch;      // channel currently being converted
   ch_idx_t           rr_ptr;      // channel where the next search starts
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] pend_nxt;
   logic [CH_W-1:0]   snap [NUM_CH];
   logic [CNT_W-1:0]  wait_cnt;

   ch_idx_t           grant;
   logic              any_pend;
   logic              take;
   logic              timeout_hit;
   logic [CH_W-1:0]   sel_bin;

   rr_pick4 u_pick (
      .pending (pending),
      .last    (prev_ch(rr_ptr)),
      .grant   (grant),
      .any     (any_pend)
   );

   assign take        = (state == ST_IDLE) && any_pend;
   assign timeout_hit = (state == ST_WAIT) && !conv.conv_done &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign sel_bin     = ch_bin[grant*CH_W +: CH_W];
   assign busy        = (state != ST_IDLE);

   // Pending update. Priority, lowest to highest: clear on issue, re-arm on
   // timeout, input differs from snapshot, refresh. The channel being issued
   // this cycle is excluded from the difference test because its snapshot is
   // being overwritten with the current input at the same edge.
   always_comb begin
      pend_nxt = pending;
      for (int k = 0; k < NUM_CH; k++) begin
         if (take && (grant == ch_idx_t'(k))) begin
            pend_nxt[k] = 1'b0;
         end
         if (timeout_hit && (cur_ch == ch_idx_t'(k))) begin
            pend_nxt[k] = 1'b1;
         end
         if ((ch_bin[k*CH_W +: CH_W] != snap[k]) &&
             !(take && (grant == ch_idx_t'(k)))) begin
            pend_nxt[k] = 1'b1;
         end
         if (refresh_tick) begin
            pend_nxt[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk100Mhz or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         cur_ch          <= '0;
         rr_ptr          <= '0;
         pending         <= '0;
         wait_cnt        <= '0;
         timeout_err     <= 1'b0;
         conv.conv_start <= 1'b0;
         conv.conv_bin   <= '0;
         bcd_out         <= '0;
         bcd_valid       <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            snap[k] <= '0;
         end
      end else begin
         pending         <= pend_nxt;
         conv.conv_start <= 1'b0;
         case (state)
            // Select the next channel; operand and start pulse are registered
            // so they are presented during the ISSUE cycle.
            ST_IDLE: begin
               if (any_pend) begin
                  state           <= ST_ISSUE;
                  cur_ch          <= grant;
                  rr_ptr          <= next_ch(grant);
                  snap[grant]     <= sel_bin;
                  conv.conv_bin   <= clamp_bin(sel_bin);
                  conv.conv_start <= 1'b1;
               end
            end
            // conv_done is deliberately not looked at here.
            ST_ISSUE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end
            // A done pulse in the last allowed cycle still counts as success.
            ST_WAIT: begin
               if (conv.conv_done) begin
                  state                          <= ST_STORE;
                  bcd_out[cur_ch*BCD_W +: BCD_W] <= conv.conv_bcd;
                  bcd_valid[cur_ch]              <= 1'b1;
               end else if (timeout_hit) begin
                  state       <= ST_IDLE;
                  timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_STORE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bcd_conv_scheduler
//   Directed bench: behavioural converter model (programmable latency, can be
//   silenced, can inject a stray done pulse), a monitor logging every issued
//   operand, and a scoreboard of expected operands compared in issue order.
// -----------------------------------------------------------------------------
module tb_bcd_conv_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [55:0] ch_bin;
   logic        refresh_tick;
   logic [63:0] bcd_out;
   logic [3:0]  bcd_valid;
   logic        busy;
   logic        timeout_err;

   bcd_conv_scheduler_if cif ();

   bcd_conv_scheduler #(
      .TIMEOUT_CYC (64),
      .MAX_BIN     (9999)
   ) dut (
      .clk100Mhz    (clk),
      .rst          (rst),
      .ch_bin       (ch_bin),
      .refresh_tick (refresh_tick),
      .conv         (cif),
      .bcd_out      (bcd_out),
      .bcd_valid    (bcd_valid),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int d = 0; d < 4; d++) begin
         r[d*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int clampm(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   // Converter model
   logic        model_en  = 1'b1;
   int          model_lat = 16;
   logic        inj_done  = 1'b0;
   logic        m_done    = 1'b0;
   logic [15:0] m_bcd     = '0;
   logic        m_armed   = 1'b0;
   int          m_cnt     = 0;
   logic [13:0] m_bin     = '0;

   assign cif.conv_done = m_done;
   assign cif.conv_bcd  = m_bcd;

   always @(posedge clk) begin
      if (rst !== 1'b1) begin
         m_armed <= 1'b0;
         m_done  <= 1'b0;
      end else begin
         m_done <= inj_done;
         if (inj_done) m_bcd <= 16'h7777;
         if (cif.conv_start === 1'b1 && model_en) begin
            m_armed <= 1'b1;
            m_cnt   <= model_lat;
            m_bin   <= cif.conv_bin;
         end else if (m_armed) begin
            if (m_cnt <= 1) begin
               m_done  <= 1'b1;
               m_bcd   <= to_bcd(int'(m_bin));
               m_armed <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   // Issue monitor
   logic [13:0] start_log [$];
   int          n_starts = 0;

   always @(posedge clk) begin
      if (rst === 1'b1 && cif.conv_start === 1'b1) begin
         start_log.push_back(cif.conv_bin);
         n_starts <= n_starts + 1;
      end
   end

   // Scoreboard of expected operands
   logic [13:0] exp_q [$];
   int          rd_ptr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ch(input int k, input int v);
      ch_bin[k*14 +: 14] = 14'(v);
   endtask

   task automatic expect_issue(input int v);
      exp_q.push_back(14'(clampm(v)));
   endtask

   task automatic drain(input string tag);
      logic [13:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_ptr < start_log.size()) begin
            chk(tag, 64'(start_log[rd_ptr]), 64'(e));
            rd_ptr++;
         end else begin
            chk({tag, " missing"}, 64'hFFFF_FFFF, 64'(e));
         end
      end
   endtask

   task automatic wait_starts(input int total, input int bound, input string tag);
      int c;
      c = 0;
      while (n_starts < total && c < bound) begin
         step(1);
         c++;
      end
      if (n_starts < total) chk({tag, " wait"}, 64'(n_starts), 64'(total));
   endtask

   task automatic wait_slice(input int k, input logic [15:0] v, input int bound,
                             input string tag);
      int c;
      c = 0;
      while (bcd_out[k*16 +: 16] !== v && c < bound) begin
         step(1);
         c++;
      end
      chk(tag, 64'(bcd_out[k*16 +: 16]), 64'(v));
   endtask

   task automatic wait_change(input int k, input logic [15:0] old, input int bound);
      int c;
      c = 0;
      while (bcd_out[k*16 +: 16] === old && c < bound) begin
         step(1);
         c++;
      end
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int base;

      rst          = 1'b0;
      ch_bin       = '0;
      refresh_tick = 1'b0;
      step(2);

      // Reset state
      chk("rst bcd_out",     bcd_out,                 64'h0);
      chk("rst bcd_valid",   64'(bcd_valid),          64'h0);
      chk("rst busy",        64'(busy),               64'h0);
      chk("rst timeout_err", 64'(timeout_err),        64'h0);
      chk("rst conv_start",  64'(cif.conv_start),     64'h0);
      chk("rst conv_bin",    64'(cif.conv_bin),       64'h0);

      // Single channel after reset release, with latency checks
      set_ch(0, 1234);
      expect_issue(1234);
      rst = 1'b1;
      step(1);
      chk("t1 start not yet", 64'(cif.conv_start), 64'h0);
      chk("t1 idle",          64'(busy),           64'h0);
      step(1);
      chk("t1 start",    64'(cif.conv_start), 64'h1);
      chk("t1 conv_bin", 64'(cif.conv_bin),   64'd1234);
      c = 0;
      while (cif.conv_done !== 1'b1 && c < 100) begin
         step(1);
         c++;
      end
      chk("t1 done seen",       64'(cif.conv_done), 64'h1);
      chk("t1 valid pre-store", 64'(bcd_valid),     64'h0);
      step(1);
      chk("t1 bcd_out",   64'(bcd_out[15:0]), 64'h1234);
      chk("t1 bcd_valid", 64'(bcd_valid),     64'b0001);
      step(1);
      chk("t1 back idle", 64'(busy), 64'h0);
      drain("t1 order");

      // All four channels change together, fresh round-robin state
      rst = 1'b0;
      step(2);
      chk("t2 rst bcd_valid", 64'(bcd_valid), 64'h0);
      set_ch(0, 11); set_ch(1, 22); set_ch(2, 33); set_ch(3, 44);
      expect_issue(11); expect_issue(22); expect_issue(33); expect_issue(44);
      base = n_starts;
      rst  = 1'b1;
      c = 0;
      while (bcd_valid !== 4'hF && c < 400) begin
         step(1);
         c++;
      end
      step(10);
      chk("t2 start count", 64'(n_starts - base), 64'd4);
      chk("t2 bcd_valid",   64'(bcd_valid),       64'hF);
      chk("t2 bcd_out", bcd_out, {to_bcd(44), to_bcd(33), to_bcd(22), to_bcd(11)});
      drain("t2 order");

      // Clamp
      set_ch(1, 16000);
      expect_issue(16000);
      wait_slice(1, 16'h9999, 100, "t3 bcd_out ch1");
      drain("t3 conv_bin");

      // Input change during WAIT: old result stored, then reconversion
      step(2);
      base = n_starts;
      set_ch(0, 100);
      expect_issue(100);
      wait_starts(base + 1, 50, "t4 first issue");
      step(4);
      set_ch(0, 200);
      expect_issue(200);
      wait_change(0, to_bcd(11), 100);
      chk("t4 first result", 64'(bcd_out[15:0]), 64'h0100);
      wait_change(0, 16'h0100, 100);
      chk("t4 second result", 64'(bcd_out[15:0]), 64'h0200);
      drain("t4 order");

      // Timeout with a silent converter, then retry of the same channel
      step(3);
      model_en = 1'b0;
      set_ch(2, 555);
      expect_issue(555);
      c = 0;
      while (cif.conv_start !== 1'b1 && c < 20) begin
         step(1);
         c++;
      end
      chk("t5 issue", 64'(cif.conv_start), 64'h1);
      c = 0;
      while (busy === 1'b1 && c < 200) begin
         c++;
         step(1);
      end
      chk("t5 busy cycles",  64'(c),                64'd65);
      chk("t5 timeout_err",  64'(timeout_err),      64'h1);
      chk("t5 bcd_out kept", 64'(bcd_out[47:32]),   64'h0033);
      model_en = 1'b1;
      expect_issue(555);
      step(1);
      chk("t5 reissue",          64'(cif.conv_start), 64'h1);
      chk("t5 reissue conv_bin", 64'(cif.conv_bin),   64'd555);
      wait_slice(2, 16'h0555, 100, "t5 bcd_out ch2");
      chk("t5 timeout_err sticky", 64'(timeout_err), 64'h1);
      drain("t5 order");

      // Refresh, then a second refresh during the first ISSUE cycle
      step(3);
      base = n_starts;
      refresh_tick = 1'b1;
      step(1);
      refresh_tick = 1'b0;
      c = 0;
      while (cif.conv_start !== 1'b1 && c < 10) begin
         step(1);
         c++;
      end
      refresh_tick = 1'b1;
      step(1);
      refresh_tick = 1'b0;
      expect_issue(44); expect_issue(200); expect_issue(16000);
      expect_issue(555); expect_issue(44);
      wait_starts(base + 5, 600, "t6 issues");
      step(40);
      chk("t6 start count", 64'(n_starts - base), 64'd5);
      chk("t6 idle",        64'(busy),            64'h0);
      drain("t6 order");

      // Reset during WAIT and a late done pulse after release
      base = n_starts;
      set_ch(0, 300);
      expect_issue(300);
      wait_starts(base + 1, 50, "t7 issue");
      drain("t7 order");
      step(4);
      ch_bin = '0;
      rst    = 1'b0;
      step(1);
      chk("t7 rst bcd_out",     bcd_out,             64'h0);
      chk("t7 rst bcd_valid",   64'(bcd_valid),      64'h0);
      chk("t7 rst busy",        64'(busy),           64'h0);
      chk("t7 rst timeout_err", 64'(timeout_err),    64'h0);
      chk("t7 rst conv_start",  64'(cif.conv_start), 64'h0);
      chk("t7 rst conv_bin",    64'(cif.conv_bin),   64'h0);
      step(1);
      rst  = 1'b1;
      base = n_starts;
      step(2);
      inj_done = 1'b1;
      step(1);
      inj_done = 1'b0;
      step(5);
      chk("t7 late bcd_out",   bcd_out,                64'h0);
      chk("t7 late bcd_valid", 64'(bcd_valid),         64'h0);
      chk("t7 late busy",      64'(busy),              64'h0);
      chk("t7 late starts",    64'(n_starts - base),   64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
